haz_ctrl_seq: RTL and testbench
===============================

// Module: haz_ctrl_seq
// PURPOSE
//  Sequenced hazard-detection unit for the 5-stage pipeline; successor to the 1-cycle combinational load-use detector.
//  Compares ID source regs against EX and MEM destinations; owns a bubble counter for multi-cycle stalls (load-use, branch-on-load).
//  Freezes on cache miss; a taken-branch flush overrides any stall.
//  Drives PC hold, IF/ID write enable, ID/EX bubble insert and IF/ID flush.
// PARAMETERS
//  REG_AW    3  register-address width
//  LD_LAT    1  bubbles for ALU consumer of a load in EX (1..3)
//  BR_LD_LAT 2  bubbles for branch/jump-reg consumer of a load in EX (>=LD_LAT, <=3)
//  ZERO_REG  0  1: register 0 is hardwired zero, never a hazard source
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  id_valid     in   1        ID holds a real instruction
//  id_is_bj     in   1        ID instr is a branch / register jump (resolves in ID)
//  id_rd1_en    in   1        ID reads rs1
//  id_rd2_en    in   1        ID reads rs2
//  id_rs1       in   REG_AW   ID source 1
//  id_rs2       in   REG_AW   ID source 2
//  ex_reg_wr    in   1        EX instr writes a register
//  ex_mem_rd    in   1        EX instr is a load
//  ex_wr_reg    in   REG_AW   EX destination
//  mem_reg_wr   in   1        MEM instr writes a register
//  mem_mem_rd   in   1        MEM instr is a load
//  mem_wr_reg   in   REG_AW   MEM destination
//  cache_stall  in   1        memory busy; whole pipe frozen this cycle
//  flush_req    in   1        taken branch / mispredict from EX; kill IF/ID
//  pc_hold      out  1        hold PC
//  wrt_if_id    out  1        IF/ID write enable
//  bubble_id_ex out  1        load NOP into ID/EX
//  flush_if_id  out  1        replace IF/ID with NOP
//  stall_c      out  2        cause: 00 none, 01 data, 10 branch-on-load, 11 cache freeze
//  busy         out  1        counter state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, cnt 0.
//   During reset, outputs take their IDLE/no-hazard values:
//   pc_hold=0, wrt_if_id=1, bubble_id_ex=0, flush_if_id=0, stall_c=00, busy=0.
//  Match: mX = rdN_en & (rsN==X_wr_reg) & X_reg_wr & ~(ZERO_REG & X_wr_reg==0).
//   All matches are gated by id_valid.
//  Required bubbles N, evaluated in IDLE only; the largest applicable case wins:
//   load in EX, non-bj consumer, either src:  N=LD_LAT,    cause 01
//   load in EX, bj consumer, rs1:             N=BR_LD_LAT, cause 10
//   ALU in EX,  bj consumer, rs1:             N=1,         cause 01
//   load in MEM, bj consumer, rs1:            N=BR_LD_LAT-1 (skip if 0), cause 10
//   otherwise N=0.
//  FSM IDLE/STALL/FREEZE; outputs combinational from state plus inputs.
//  Stall cycle (any state): pc_hold=1, wrt_if_id=0, bubble_id_ex=1.
//  Priority: rst_n > flush_req > cache_stall > stall.
//  IDLE:
//   N>0: stall this cycle (zero-latency detect); cnt<=N-1; go STALL if N>1, else stay IDLE.
//  STALL:
//   Stall, stall_c = latched cause.
//   cnt==0 at edge -> IDLE, else cnt<=cnt-1.
//   No re-evaluation while in STALL.
//  FREEZE (entered from any state when cache_stall=1):
//   pc_hold=1, wrt_if_id=0, bubble_id_ex=0 (ID/EX also frozen), stall_c=11.
//   cnt and latched cause are held.
//   cache_stall falls -> return to saved state (IDLE or STALL).
//  flush_req=1:
//   flush_if_id=1, bubble_id_ex=1, pc_hold=0, wrt_if_id=1.
//   cnt<=0, state<=IDLE; applies even during cache_stall (flush wins).
//  Async reset mid-stall or mid-freeze: immediate IDLE, no residual bubbles.
//  Detection is ignored in FREEZE; it is re-evaluated on return to IDLE.
// TESTING
//  1. lw r3 in EX, add using r3 in ID, LD_LAT=1 -> 1 cycle: pc_hold=1, wrt_if_id=0, bubble=1, stall_c=01; next cycle IDLE.
//  2. lw r2 in EX, beqz r2 in ID, BR_LD_LAT=2 -> 2 consecutive bubble cycles, stall_c=10, busy=1 in 2nd cycle; then clean.
//  3. Case 2 with cache_stall=1 for 3 cycles after the 1st bubble -> 3 cycles stall_c=11, bubble=0; then 1 remaining bubble.
//  4. flush_req=1 in STALL with cnt=1 -> flush_if_id=1, pc_hold=0; next cycle IDLE, busy=0.
//  5. ZERO_REG=1, lw r0 in EX, add reads r0 -> no stall; ZERO_REG=0 -> 1-cycle stall.
//  6. rst_n low in STALL mid-count -> outputs immediately at reset values; no bubble after release.

Source files
------------

// File: rtl/haz_ctrl_if.sv
// Hazard-unit bundle: ID/EX/MEM register-usage info in, pipeline control out.
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface haz_ctrl_if #(
    parameter int unsigned REG_AW = 3
);
    logic              id_valid;
    logic              id_is_bj;
    logic              id_rd1_en;
    logic              id_rd2_en;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic [REG_AW-1:0] ex_wr_reg;
    logic              mem_reg_wr;
    logic              mem_mem_rd;
    logic [REG_AW-1:0] mem_wr_reg;
    logic              cache_stall;
    logic              flush_req;
    logic              pc_hold;
    logic              wrt_if_id;
    logic              bubble_id_ex;
    logic              flush_if_id;
    logic [1:0]        stall_c;
    logic              busy;

    modport master (
        output id_valid, id_is_bj, id_rd1_en, id_rd2_en, id_rs1, id_rs2,
        output ex_reg_wr, ex_mem_rd, ex_wr_reg, mem_reg_wr, mem_mem_rd, mem_wr_reg,
        output cache_stall, flush_req,
        input  pc_hold, wrt_if_id, bubble_id_ex, flush_if_id, stall_c, busy
    );

    modport slave (
        input  id_valid, id_is_bj, id_rd1_en, id_rd2_en, id_rs1, id_rs2,
        input  ex_reg_wr, ex_mem_rd, ex_wr_reg, mem_reg_wr, mem_mem_rd, mem_wr_reg,
        input  cache_stall, flush_req,
        output pc_hold, wrt_if_id, bubble_id_ex, flush_if_id, stall_c, busy
    );
endinterface

// File: rtl/haz_ctrl_seq.sv
// Sequenced hazard-detection unit: zero-latency load-use / branch-on-load detect with a
// bubble counter, cache-miss freeze that preserves the counter, and flush override.
module haz_ctrl_seq #(
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned LD_LAT    = 1,
    parameter int unsigned BR_LD_LAT = 2,
    parameter bit          ZERO_REG  = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    haz_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StStall, StFreeze} state_e;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseData  = 2'b01;
    localparam logic [1:0] CauseBr    = 2'b10;
    localparam logic [1:0] CauseCache = 2'b11;
    localparam logic [1:0] LdN        = 2'(LD_LAT);
    localparam logic [1:0] BrN        = 2'(BR_LD_LAT);
    localparam logic [1:0] BrMemN     = 2'(BR_LD_LAT - 1);

    state_e     state_q, state_d, ret_q, ret_d, eff_state;
    logic [1:0] cnt_q, cnt_d, cause_q, cause_d;
    logic [1:0] need_n, need_c, stall_cause;
    logic       stall, ex_zero, mem_zero, m_ex1, m_ex2, m_mem1;
    logic       pc_hold, wrt_if_id, bubble_id_ex, flush_if_id, busy;
    logic [1:0] stall_c;

    assign ex_zero  = ZERO_REG && (bus.ex_wr_reg == '0);
    assign mem_zero = ZERO_REG && (bus.mem_wr_reg == '0);
    assign m_ex1  = bus.id_valid & bus.id_rd1_en & (bus.id_rs1 == bus.ex_wr_reg) &
                    bus.ex_reg_wr & ~ex_zero;
    assign m_ex2  = bus.id_valid & bus.id_rd2_en & (bus.id_rs2 == bus.ex_wr_reg) &
                    bus.ex_reg_wr & ~ex_zero;
    assign m_mem1 = bus.id_valid & bus.id_rd1_en & (bus.id_rs1 == bus.mem_wr_reg) &
                    bus.mem_reg_wr & ~mem_zero;

    // Bubble requirement; the EX cases are mutually exclusive, MEM only wins if strictly larger.
    always_comb begin
        need_n = 2'd0;
        need_c = CauseNone;
        if (bus.ex_mem_rd && !bus.id_is_bj && (m_ex1 || m_ex2)) begin
            need_n = LdN;
            need_c = CauseData;
        end else if (bus.ex_mem_rd && bus.id_is_bj && m_ex1) begin
            need_n = BrN;
            need_c = CauseBr;
        end else if (!bus.ex_mem_rd && bus.id_is_bj && m_ex1) begin
            need_n = 2'd1;
            need_c = CauseData;
        end
        if (bus.mem_mem_rd && bus.id_is_bj && m_mem1 && (BrMemN > need_n)) begin
            need_n = BrMemN;
            need_c = CauseBr;
        end
    end

    // In FREEZE with the cache released, act as the saved state in that same cycle.
    assign eff_state = (state_q == StFreeze) ? ret_q : state_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        stall        = 1'b0;
        stall_cause  = CauseNone;
        pc_hold      = 1'b0;
        wrt_if_id    = 1'b1;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        stall_c      = CauseNone;
        busy         = (state_q != StIdle);
        if (!rst_n) begin
            busy = 1'b0;
        end else if (bus.flush_req) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            state_d      = StIdle;
            ret_d        = StIdle;
            cnt_d        = 2'd0;
        end else if (bus.cache_stall) begin
            pc_hold   = 1'b1;
            wrt_if_id = 1'b0;
            stall_c   = CauseCache;
            state_d   = StFreeze;
            ret_d     = eff_state;
        end else if (eff_state == StStall) begin
            // cnt counts bubbles still owed, including this cycle's.
            stall       = 1'b1;
            stall_cause = cause_q;
            cnt_d       = cnt_q - 2'd1;
            state_d     = (cnt_q <= 2'd1) ? StIdle : StStall;
        end else begin
            state_d = StIdle;
            if (need_n != 2'd0) begin
                stall       = 1'b1;
                stall_cause = need_c;
                cause_d     = need_c;
                cnt_d       = need_n - 2'd1;
                state_d     = (need_n > 2'd1) ? StStall : StIdle;
            end
        end
        if (stall) begin
            pc_hold      = 1'b1;
            wrt_if_id    = 1'b0;
            bubble_id_ex = 1'b1;
            stall_c      = stall_cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ret_q   <= StIdle;
            cnt_q   <= 2'd0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign bus.pc_hold      = pc_hold;
    assign bus.wrt_if_id    = wrt_if_id;
    assign bus.bubble_id_ex = bubble_id_ex;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.stall_c      = stall_c;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_haz_ctrl_seq.sv
// Directed bench for haz_ctrl_seq: scoreboard queue of expected control vectors,
// checked on the falling edge; a second instance with ZERO_REG=1 shadows the same inputs.
module tb_haz_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    haz_ctrl_if #(.REG_AW(3)) bus ();
    haz_ctrl_if #(.REG_AW(3)) bus_z ();

    haz_ctrl_seq #(.REG_AW(3), .LD_LAT(1), .BR_LD_LAT(2), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    haz_ctrl_seq #(.REG_AW(3), .LD_LAT(1), .BR_LD_LAT(2), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bus_z)
    );

    assign bus_z.id_valid    = bus.id_valid;
    assign bus_z.id_is_bj    = bus.id_is_bj;
    assign bus_z.id_rd1_en   = bus.id_rd1_en;
    assign bus_z.id_rd2_en   = bus.id_rd2_en;
    assign bus_z.id_rs1      = bus.id_rs1;
    assign bus_z.id_rs2      = bus.id_rs2;
    assign bus_z.ex_reg_wr   = bus.ex_reg_wr;
    assign bus_z.ex_mem_rd   = bus.ex_mem_rd;
    assign bus_z.ex_wr_reg   = bus.ex_wr_reg;
    assign bus_z.mem_reg_wr  = bus.mem_reg_wr;
    assign bus_z.mem_mem_rd  = bus.mem_mem_rd;
    assign bus_z.mem_wr_reg  = bus.mem_wr_reg;
    assign bus_z.cache_stall = bus.cache_stall;
    assign bus_z.flush_req   = bus.flush_req;

    // {pc_hold, wrt_if_id, bubble_id_ex, flush_if_id, stall_c[1:0], busy}
    localparam logic [6:0] Idle   = 7'b0100000;
    localparam logic [6:0] Data0  = 7'b1010010;
    localparam logic [6:0] Data1  = 7'b1010011;
    localparam logic [6:0] Br0    = 7'b1010100;
    localparam logic [6:0] Br1    = 7'b1010101;
    localparam logic [6:0] Frz0   = 7'b1000110;
    localparam logic [6:0] Frz1   = 7'b1000111;
    localparam logic [6:0] Flush0 = 7'b0111000;
    localparam logic [6:0] Flush1 = 7'b0111001;

    typedef struct {
        string      tag;
        bit         zsel;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input bit zsel, input logic [6:0] exp);
        exp_t e;
        e.tag  = tag;
        e.zsel = zsel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_step();
        exp_t       e;
        logic [6:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.zsel)
                obs = {bus_z.pc_hold, bus_z.wrt_if_id, bus_z.bubble_id_ex, bus_z.flush_if_id,
                       bus_z.stall_c, bus_z.busy};
            else
                obs = {bus.pc_hold, bus.wrt_if_id, bus.bubble_id_ex, bus.flush_if_id,
                       bus.stall_c, bus.busy};
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_valid    = 1'b0;
        bus.id_is_bj    = 1'b0;
        bus.id_rd1_en   = 1'b0;
        bus.id_rd2_en   = 1'b0;
        bus.id_rs1      = 3'd0;
        bus.id_rs2      = 3'd0;
        bus.ex_reg_wr   = 1'b0;
        bus.ex_mem_rd   = 1'b0;
        bus.ex_wr_reg   = 3'd0;
        bus.mem_reg_wr  = 1'b0;
        bus.mem_mem_rd  = 1'b0;
        bus.mem_wr_reg  = 3'd0;
        bus.cache_stall = 1'b0;
        bus.flush_req   = 1'b0;
    endtask

    // ID instruction reading rs1 (and optionally rs2)
    task automatic set_id(input bit bj, input logic [2:0] rs1, input bit rd2, input logic [2:0] rs2);
        bus.id_valid  = 1'b1;
        bus.id_is_bj  = bj;
        bus.id_rd1_en = 1'b1;
        bus.id_rs1    = rs1;
        bus.id_rd2_en = rd2;
        bus.id_rs2    = rs2;
    endtask

    task automatic set_ex(input bit ld, input logic [2:0] rd);
        bus.ex_reg_wr = 1'b1;
        bus.ex_mem_rd = ld;
        bus.ex_wr_reg = rd;
    endtask

    task automatic set_mem(input bit ld, input logic [2:0] rd);
        bus.mem_reg_wr = 1'b1;
        bus.mem_mem_rd = ld;
        bus.mem_wr_reg = rd;
    endtask

    initial begin
        clear_in();
        #1;
        // Reset with a live load-use pattern on the inputs: outputs stay idle.
        set_ex(1'b1, 3'd3); set_id(1'b0, 3'd3, 1'b0, 3'd0);
        push("reset_idle", 1'b0, Idle);
        push("reset_idle_z", 1'b1, Idle);
        check_step();
        rst_n = 1'b1;
        clear_in();
        push("post_reset", 1'b0, Idle);
        check_step();

        // Load-use, ALU consumer on rs1: one bubble.
        set_ex(1'b1, 3'd3); set_id(1'b0, 3'd3, 1'b0, 3'd0);
        push("lduse_rs1", 1'b0, Data0);
        check_step();
        clear_in();
        push("lduse_after", 1'b0, Idle);
        check_step();
        // Load-use on rs2.
        set_ex(1'b1, 3'd6); set_id(1'b0, 3'd1, 1'b1, 3'd6);
        push("lduse_rs2", 1'b0, Data0);
        check_step();
        clear_in();
        // No hazard when ID is not valid.
        set_ex(1'b1, 3'd6); set_id(1'b0, 3'd6, 1'b0, 3'd0); bus.id_valid = 1'b0;
        push("invalid_id", 1'b0, Idle);
        check_step();
        clear_in();
        // ALU in EX feeding an ALU consumer: forwarded, no stall.
        set_ex(1'b0, 3'd4); set_id(1'b0, 3'd4, 1'b1, 3'd4);
        push("alu_fwd", 1'b0, Idle);
        check_step();
        // ALU in EX feeding a branch: one data bubble.
        set_ex(1'b0, 3'd4); set_id(1'b1, 3'd4, 1'b0, 3'd0);
        push("alu_bj", 1'b0, Data0);
        check_step();
        clear_in();
        // Load in MEM feeding a branch: BR_LD_LAT-1 = 1 bubble.
        set_mem(1'b1, 3'd5); set_id(1'b1, 3'd5, 1'b0, 3'd0);
        push("mem_ld_bj", 1'b0, Br0);
        check_step();
        clear_in();
        push("mem_ld_bj_after", 1'b0, Idle);
        check_step();

        // Branch-on-load: two bubbles; the load has moved to MEM but STALL does not re-evaluate.
        set_ex(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        push("brld_b1", 1'b0, Br0);
        check_step();
        clear_in(); set_mem(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        push("brld_b2", 1'b0, Br1);
        check_step();
        clear_in();
        push("brld_after", 1'b0, Idle);
        check_step();

        // Branch-on-load with a 3-cycle cache freeze after the first bubble.
        set_ex(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        push("frz_b1", 1'b0, Br0);
        check_step();
        clear_in(); set_mem(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            bus.cache_stall = 1'b1;
            push($sformatf("frz_cycle%0d", i), 1'b0, Frz1);
            check_step();
        end
        bus.cache_stall = 1'b0;
        push("frz_resume_b2", 1'b0, Br1);
        check_step();
        clear_in();
        push("frz_after", 1'b0, Idle);
        check_step();

        // Freeze from IDLE hides a hazard; it is detected when the cache releases.
        set_ex(1'b1, 3'd3); set_id(1'b0, 3'd3, 1'b0, 3'd0); bus.cache_stall = 1'b1;
        push("idle_frz0", 1'b0, Frz0);
        check_step();
        push("idle_frz1", 1'b0, Frz1);
        check_step();
        bus.cache_stall = 1'b0;
        push("idle_frz_release", 1'b0, Data1);
        check_step();
        clear_in();
        push("idle_frz_after", 1'b0, Idle);
        check_step();

        // Flush in STALL with one bubble owed.
        set_ex(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        push("fl_b1", 1'b0, Br0);
        check_step();
        clear_in(); bus.flush_req = 1'b1;
        push("fl_flush", 1'b0, Flush1);
        check_step();
        clear_in();
        push("fl_after", 1'b0, Idle);
        check_step();
        // Flush beats a cache freeze and a pending hazard.
        set_ex(1'b1, 3'd3); set_id(1'b0, 3'd3, 1'b0, 3'd0);
        bus.cache_stall = 1'b1; bus.flush_req = 1'b1;
        push("fl_over_cache", 1'b0, Flush0);
        check_step();
        clear_in();
        push("fl_over_after", 1'b0, Idle);
        check_step();

        // Register 0 destination: hazard only without the zero-register rule.
        set_ex(1'b1, 3'd0); set_id(1'b0, 3'd0, 1'b0, 3'd0);
        push("r0_zero0", 1'b0, Data0);
        push("r0_zero1", 1'b1, Idle);
        check_step();
        clear_in();
        push("r0_after", 1'b0, Idle);
        push("r0_after_z", 1'b1, Idle);
        check_step();

        // Async reset mid-stall: outputs drop to idle at once, no leftover bubble.
        set_ex(1'b1, 3'd2); set_id(1'b1, 3'd2, 1'b0, 3'd0);
        push("rst_b1", 1'b0, Br0);
        check_step();
        rst_n = 1'b0;
        push("rst_mid_stall", 1'b0, Idle);
        check_step();
        rst_n = 1'b1;
        clear_in();
        push("rst_release", 1'b0, Idle);
        check_step();
        push("rst_release2", 1'b0, Idle);
        check_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
